// File: rtl/video_pattern_source.sv
// Avalon-ST RGB565 test-frame generator: solid, colour bars, gradient, checkerboard.
// One packet per frame; config is latched at frame start so it is stable for a whole frame.
module video_pattern_source #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        source_valid_out,
    input  logic        source_ready_in,
    output logic [15:0] source_data_out,
    output logic        source_startofpacket_out,
    output logic        source_endofpacket_out,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int unsigned XW      = $clog2(WIDTH);
    localparam int unsigned YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned BAR_LEN = WIDTH / 8;

    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] BAR_LAST = XW'(BAR_LEN - 1);

    typedef enum logic [1:0] {StIdle, StStart, StStream} state_t;

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [2:0]    r_bar;
    logic [XW-1:0] r_bpos;   // column within the current colour bar
    logic [1:0]    r_pat;
    logic [15:0]   r_col;
    logic          r_valid;
    logic [15:0]   r_data;
    logic          r_sop;
    logic          r_eop;
    logic          r_frame_done;
    logic [15:0]   r_frame_count;

    logic          w_xfer;
    logic          w_last;
    logic [15:0]   w_fc_inc;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic [2:0]    w_nbar;
    logic [XW-1:0] w_nbpos;

    function automatic logic [15:0] f_bar_color(input logic [2:0] bar);
        logic [15:0] c;
        unique case (bar)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] f_pixel(input logic [1:0]    pat,
                                            input logic [15:0]   col,
                                            input logic [XW-1:0] x,
                                            input logic [YW-1:0] y,
                                            input logic [2:0]    bar,
                                            input logic [4:0]    fc5);
        logic [4:0]  x5;
        logic [5:0]  y6;
        logic [15:0] p;
        x5 = 5'(x);
        y6 = 6'(y);
        unique case (pat)
            2'b00:   p = col;
            2'b01:   p = f_bar_color(bar);
            2'b10:   p = {x5, y6, fc5};
            default: p = (x5[3] ^ y6[3]) ? 16'hFFFF : 16'h0000;
        endcase
        return p;
    endfunction

    assign w_xfer   = r_valid & source_ready_in;
    assign w_last   = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_fc_inc = r_frame_count + 16'd1;

    // Raster position of the pixel following the current one (only used when not last).
    always_comb begin
        w_nx    = r_x + XW'(1);
        w_ny    = r_y;
        w_nbar  = r_bar;
        w_nbpos = r_bpos + XW'(1);
        if (r_x == X_LAST) begin
            w_nx    = '0;
            w_ny    = r_y + YW'(1);
            w_nbar  = '0;
            w_nbpos = '0;
        end else if (r_bpos == BAR_LAST) begin
            w_nbar  = r_bar + 3'd1;
            w_nbpos = '0;
        end
    end

    // Frame FSM with registered stream outputs; outputs only move on a transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_x           <= '0;
            r_y           <= '0;
            r_bar         <= '0;
            r_bpos        <= '0;
            r_pat         <= '0;
            r_col         <= '0;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_sop         <= 1'b0;
            r_eop         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (enable) r_state <= StStart;
                end
                StStart: begin
                    r_pat   <= pattern_sel;
                    r_col   <= solid_color;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_bar   <= '0;
                    r_bpos  <= '0;
                    r_valid <= 1'b1;
                    r_data  <= f_pixel(pattern_sel, solid_color, '0, '0, 3'd0,
                                       r_frame_count[4:0]);
                    r_sop   <= 1'b1;
                    r_eop   <= 1'b0;
                    r_state <= StStream;
                end
                StStream: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_frame_done  <= 1'b1;
                            r_frame_count <= w_fc_inc;
                            r_x           <= '0;
                            r_y           <= '0;
                            r_bar         <= '0;
                            r_bpos        <= '0;
                            r_eop         <= 1'b0;
                            if (enable) begin
                                // Back-to-back frame: relatch config, present (0,0) now.
                                r_pat  <= pattern_sel;
                                r_col  <= solid_color;
                                r_data <= f_pixel(pattern_sel, solid_color, '0, '0, 3'd0,
                                                  w_fc_inc[4:0]);
                                r_sop  <= 1'b1;
                            end else begin
                                r_valid <= 1'b0;
                                r_data  <= '0;
                                r_sop   <= 1'b0;
                                r_state <= StIdle;
                            end
                        end else begin
                            r_x    <= w_nx;
                            r_y    <= w_ny;
                            r_bar  <= w_nbar;
                            r_bpos <= w_nbpos;
                            r_data <= f_pixel(r_pat, r_col, w_nx, w_ny, w_nbar,
                                              r_frame_count[4:0]);
                            r_sop  <= 1'b0;
                            r_eop  <= (w_nx == X_LAST) && (w_ny == Y_LAST);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign source_valid_out         = r_valid;
    assign source_data_out          = r_data;
    assign source_startofpacket_out = r_sop;
    assign source_endofpacket_out   = r_eop;
    assign frame_done               = r_frame_done;
    assign frame_count              = r_frame_count;

endmodule

// File: tb/tb_video_pattern_source.sv
// Bench for video_pattern_source: frame-level reference model plus directed scenarios.
module tb_video_pattern_source;

    localparam int W = 16;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        ready = 1'b0;
    logic [1:0]  psel = 2'b00;
    logic [15:0] scol = 16'h0000;
    logic        valid;
    logic [15:0] data;
    logic        sop;
    logic        eop;
    logic        fdone;
    logic [15:0] fcount;

    always #5 clk = ~clk;

    video_pattern_source #(.WIDTH(W), .HEIGHT(H)) u_dut (
        .clk                      (clk),
        .reset                    (rst_n),
        .enable                   (enable),
        .pattern_sel              (psel),
        .solid_color              (scol),
        .source_valid_out         (valid),
        .source_ready_in          (ready),
        .source_data_out          (data),
        .source_startofpacket_out (sop),
        .source_endofpacket_out   (eop),
        .frame_done               (fdone),
        .frame_count              (fcount)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [15:0] exp3 [16] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0,
                               16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
                               16'hF81F, 16'hF81F, 16'hF800, 16'hF800,
                               16'h001F, 16'h001F, 16'h0000, 16'h0000};

    // Pixel value from pattern rules, using raster index p within the frame.
    function automatic logic [15:0] exp_pix(input int pat, input logic [15:0] col,
                                            input int p, input int fc);
        int x;
        int y;
        logic [31:0] xv;
        logic [31:0] yv;
        logic [31:0] fv;
        x  = p % W;
        y  = p / W;
        xv = x;
        yv = y;
        fv = fc;
        case (pat)
            0:       return col;
            1:       return bars[x / (W / 8)];
            2:       return {xv[4:0], yv[5:0], fv[4:0]};
            default: return (((x / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Reference model: 0 idle, 1 config-latch cycle, 2 streaming pixel m_p.
    int          m_st;
    int          m_p;
    int          m_fc;
    int          m_pat;
    logic [15:0] m_col;
    logic        m_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st  <= 0;
            m_p   <= 0;
            m_fc  <= 0;
            m_pat <= 0;
            m_col <= '0;
            m_fd  <= 1'b0;
        end else begin
            m_fd <= 1'b0;
            if (m_st == 0) begin
                if (enable) m_st <= 1;
            end else if (m_st == 1) begin
                m_pat <= int'(psel);
                m_col <= scol;
                m_p   <= 0;
                m_st  <= 2;
            end else if (ready) begin
                if (m_p == N - 1) begin
                    m_fd <= 1'b1;
                    m_fc <= (m_fc + 1) % 65536;
                    m_p  <= 0;
                    if (enable) begin
                        m_pat <= int'(psel);
                        m_col <= scol;
                    end else begin
                        m_st <= 0;
                    end
                end else begin
                    m_p <= m_p + 1;
                end
            end
        end
    end

    // Compare every cycle on the falling edge, plus stall-hold checks.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_sop = 1'b0;
    logic        prev_eop = 1'b0;

    always @(negedge clk) begin
        logic exp_v;
        exp_v = (m_st == 2);
        check("valid", valid, exp_v);
        check("sop", sop, exp_v && (m_p == 0));
        check("eop", eop, exp_v && (m_p == N - 1));
        if (exp_v) check("data", data, exp_pix(m_pat, m_col, m_p, m_fc));
        else if (!rst_n) check("data_in_reset", data, 32'h0);
        check("frame_done", fdone, m_fd);
        check("frame_count", fcount, m_fc);
        if (rst_n && prev_stall) begin
            check("hold_valid", valid, 1'b1);
            check("hold_data", data, prev_data);
            check("hold_sop", sop, prev_sop);
            check("hold_eop", eop, prev_eop);
        end
        prev_stall <= rst_n && valid && !ready;
        prev_data  <= data;
        prev_sop   <= sop;
        prev_eop   <= eop;
    end

    // Accepted-beat monitor for the directed literal checks.
    typedef struct {
        logic [15:0] d;
        logic        s;
        logic        e;
        int          c;
    } beat_t;

    beat_t       acc[$];
    int          cyc = 0;
    int          fd_cnt = 0;
    logic [15:0] fc_at_fd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) acc.push_back('{data, sop, eop, cyc});
            if (fdone) begin
                fd_cnt   <= fd_cnt + 1;
                fc_at_fd <= fcount;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        acc.delete();
        fd_cnt = 0;
        rst_n  = 1'b1;
    endtask

    task automatic run_until(input int n, input bit rnd, input int budget, input string name);
        int c = 0;
        while (acc.size() < n && c < budget) begin
            @(posedge clk);
            #1;
            if (rnd) ready = 1'($urandom_range(0, 1));
            c++;
        end
        check({name, "_timeout"}, 32'(acc.size() >= n), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int en_cyc;
        int bad;
        int sc;
        int ec;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid, 1'b0);
        check("rst_count", fcount, 16'h0);

        // 1: solid frame, ready always high
        do_reset();
        psel   = 2'b00;
        scol   = 16'h1234;
        ready  = 1'b1;
        enable = 1'b1;
        en_cyc = cyc;
        run_until(N + 1, 1'b0, 200, "t1");
        if (acc.size() >= N + 1) begin
            bad = 0;
            sc  = 0;
            ec  = 0;
            for (int i = 0; i < N; i++) begin
                if (acc[i].d != 16'h1234) bad++;
                if (acc[i].s) sc++;
                if (acc[i].e) ec++;
            end
            check("t1_latency", 32'(acc[0].c - en_cyc), 32'd2);
            check("t1_sop_first", acc[0].s, 1'b1);
            check("t1_eop_last", acc[N-1].e, 1'b1);
            check("t1_sop_count", sc, 1);
            check("t1_eop_count", ec, 1);
            check("t1_data_bad", bad, 0);
            check("t1_next_sop", acc[N].s, 1'b1);
            check("t1_next_data", acc[N].d, 16'h1234);
            check("t1_no_bubble", 32'(acc[N].c - acc[N-1].c), 32'd1);
            check("t1_fd_count", fd_cnt, 1);
            check("t1_fc_at_fd", fc_at_fd, 16'h1);
        end

        // 2: same config, random backpressure
        do_reset();
        psel   = 2'b00;
        scol   = 16'h1234;
        enable = 1'b1;
        run_until(2 * N + 2, 1'b1, 3000, "t2");
        bad = 0;
        for (int i = 0; i < acc.size() && i < 2 * N + 2; i++) begin
            if (acc[i].d != 16'h1234 || acc[i].s != (i % N == 0) || acc[i].e != (i % N == N - 1))
                bad++;
        end
        check("t2_seq_bad", bad, 0);

        // 3: colour bars, first line
        do_reset();
        psel   = 2'b01;
        ready  = 1'b1;
        enable = 1'b1;
        run_until(W, 1'b0, 200, "t3");
        for (int i = 0; i < W && i < acc.size(); i++) check("t3_bar", acc[i].d, exp3[i]);

        // 4: enable dropped at pixel 10
        do_reset();
        psel   = 2'b00;
        scol   = 16'hBEEF;
        ready  = 1'b1;
        enable = 1'b1;
        run_until(10, 1'b0, 200, "t4");
        enable = 1'b0;
        repeat (N + 20) @(posedge clk);
        #1;
        check("t4_beats", acc.size(), N);
        if (acc.size() >= N) check("t4_eop", acc[N-1].e, 1'b1);
        check("t4_fd_count", fd_cnt, 1);
        check("t4_idle_valid", valid, 1'b0);
        check("t4_count", fcount, 16'h1);

        // 5: pattern change mid-frame applies to next frame only
        do_reset();
        psel   = 2'b00;
        scol   = 16'h1234;
        ready  = 1'b1;
        enable = 1'b1;
        run_until(5, 1'b0, 200, "t5a");
        psel = 2'b11;
        run_until(N + 2 * W, 1'b0, 400, "t5b");
        if (acc.size() >= N + 2 * W) begin
            bad = 0;
            for (int i = 0; i < N; i++) if (acc[i].d != 16'h1234) bad++;
            check("t5_solid_bad", bad, 0);
            check("t5_ck_0_0", acc[N].d, 16'h0000);
            check("t5_ck_7_0", acc[N+7].d, 16'h0000);
            check("t5_ck_8_0", acc[N+8].d, 16'hFFFF);
            check("t5_ck_8_1", acc[N+W+8].d, 16'hFFFF);
        end

        // 6: asynchronous reset mid-frame while stalled
        do_reset();
        psel   = 2'b00;
        scol   = 16'h1234;
        ready  = 1'b1;
        enable = 1'b1;
        run_until(N + 20, 1'b0, 400, "t6");
        ready = 1'b0;
        @(posedge clk);
        #1;
        check("t6_count_before", fcount, 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", valid, 1'b0);
        check("t6_rst_data", data, 16'h0);
        check("t6_rst_sop", sop, 1'b0);
        check("t6_rst_eop", eop, 1'b0);
        check("t6_rst_fd", fdone, 1'b0);
        check("t6_rst_count", fcount, 16'h0);
        @(posedge clk);
        #1;
        acc.delete();
        ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_edge1_valid", valid, 1'b0);
        @(posedge clk);
        #1;
        check("t6_edge2_valid", valid, 1'b1);
        check("t6_edge2_sop", sop, 1'b1);
        check("t6_edge2_data", data, 16'h1234);

        // 7: randomized config, enable and backpressure against the model
        do_reset();
        enable = 1'b1;
        psel   = 2'b10;
        scol   = 16'($urandom);
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #1;
            ready = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            if ($urandom_range(0, 99) < 4) psel = 2'($urandom);
            if ($urandom_range(0, 99) < 4) scol = 16'($urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
